mem_wb_stage: RTL

//  Memory + write-back half of the 16-bit pipelined CPU, directly downstream of EX.

---
 rtl/mem_wb_stage_pkg.sv | 25 ++
 rtl/mem_wb_stage_data_memory.sv | 22 ++
 rtl/mem_wb_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB half of the 16-bit CPU: memory geometry,
// the nop encoding, control-vector field positions and the MemtoReg mux helper.
package mem_wb_stage_pkg;

  localparam int DMEM_WORDS = 1024;
  localparam int AW         = 10;

  localparam logic [15:0] NOP_IR = 16'h0000;

  // Control vector {RegDst,AluSrc,MemtoReg,RegWrite,MemWrite,Branch,AluCtrl[2:0]}
  localparam int CV_ALUCTRL_LSB = 0;
  localparam int CV_BRANCH      = 3;
  localparam int CV_MEMWRITE    = 4;
  localparam int CV_REGWRITE    = 5;
  localparam int CV_MEMTOREG    = 6;
  localparam int CV_ALUSRC      = 7;
  localparam int CV_REGDST      = 8;

  function automatic logic [15:0] mux2x1_16bit(input logic sel,
                                               input logic [15:0] in0,
                                               input logic [15:0] in1);
    return sel ? in1 : in0;
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory: asynchronous read, write on the falling clock edge,
// contents deliberately not reset.
module mem_wb_stage_data_memory #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wd,
  output logic [15:0]   rd
);

  logic [15:0] mem [WORDS];

  assign rd = mem[addr];

  always_ff @(negedge clk) begin
    if (we) mem[addr] <= wd;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers around the data memory, with a flush path
// that turns the incoming instruction into a nop bubble.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DMEM_WORDS = mem_wb_stage_pkg::DMEM_WORDS,
  parameter int AW         = mem_wb_stage_pkg::AW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic [1:0]  ex_wr,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic        ex_memwrite,
  input  logic [15:0] ex_ir,
  input  logic        flush,
  output logic [1:0]  exmem_wr,
  output logic        exmem_regwrite,
  output logic [15:0] exmem_alu_out,
  output logic [1:0]  wb_wr,
  output logic [15:0] wb_wd,
  output logic        wb_regwrite,
  output logic [15:0] mem_ir,
  output logic [15:0] wb_ir
);

  logic          exmem_valid;
  logic          exmem_memtoreg;
  logic          exmem_memwrite;
  logic [15:0]   exmem_store_data;
  logic [AW-1:0] mem_idx;
  logic [15:0]   mem_rd;
  logic          mem_we;

  // Bit 0 is the byte offset; bits above AW alias back into the array.
  assign mem_idx = exmem_alu_out[AW:1];
  assign mem_we  = exmem_memwrite && exmem_valid;

  // RegWrite is gated at capture so the forwarding unit never sees a write to $0.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      exmem_valid      <= 1'b0;
      exmem_wr         <= 2'b00;
      exmem_regwrite   <= 1'b0;
      exmem_memtoreg   <= 1'b0;
      exmem_memwrite   <= 1'b0;
      exmem_alu_out    <= 16'h0000;
      exmem_store_data <= 16'h0000;
      mem_ir           <= NOP_IR;
    end else begin
      exmem_valid      <= !flush;
      exmem_wr         <= ex_wr;
      exmem_regwrite   <= ex_regwrite && !flush && (ex_wr != 2'b00);
      exmem_memtoreg   <= ex_memtoreg && !flush;
      exmem_memwrite   <= ex_memwrite && !flush;
      exmem_alu_out    <= ex_alu_out;
      exmem_store_data <= ex_store_data;
      mem_ir           <= flush ? NOP_IR : ex_ir;
    end
  end

  mem_wb_stage_data_memory #(
    .WORDS (DMEM_WORDS),
    .AW    (AW)
  ) u_dmem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_idx),
    .wd   (exmem_store_data),
    .rd   (mem_rd)
  );

  // mem_rd here is the pre-write value; only one instruction occupies MEM.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wb_wr       <= 2'b00;
      wb_wd       <= 16'h0000;
      wb_regwrite <= 1'b0;
      wb_ir       <= NOP_IR;
    end else begin
      wb_wr       <= exmem_wr;
      wb_wd       <= mux2x1_16bit(exmem_memtoreg, exmem_alu_out, mem_rd);
      wb_regwrite <= exmem_regwrite && exmem_valid;
      wb_ir       <= mem_ir;
    end
  end

endmodule
